uart_mmio_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_mmio_ctrl_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_mmio_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART controller: register addresses,
// CON register bit positions and the TX state encoding.
package uart_pkg;
   localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
   localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
   localparam logic [31:0] ADDR_CON = 32'h4000_0020;

   localparam int CON_TX_EMPTY  = 0;
   localparam int CON_TX_FULL   = 1;
   localparam int CON_RX_VALID  = 2;
   localparam int CON_TX_OVF    = 3;
   localparam int CON_RX_OVR    = 4;
   localparam int CON_TX_ACTIVE = 5;
   localparam int CON_RX_IRQ_EN = 6;
   localparam int CON_TX_IRQ_EN = 7;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_START   = 2'd1,
      TX_WAIT_HI = 2'd2,
      TX_WAIT_LO = 2'd3
   } tx_state_e;
endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU data-bus view of the UART controller: address, store data, strobes and
// the combinational load data returned by the block.
interface uart_mmio_ctrl_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        mem_write;
   logic        mem_read;

   modport master (output addr, wdata, mem_write, mem_read, input rdata);
   modport slave  (input addr, wdata, mem_write, mem_read, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for outgoing bytes. A push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TXD/RXD/CON register decode, TX drain FSM
// with start/busy handshake to the sender, RX holding register and irq.
module uart_mmio_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_mmio_ctrl_if.slave        bus,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   input  logic [7:0]             rx_data,
   input  logic                   rx_done,
   output logic                   irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e   state_q, state_d;
   logic [7:0]  tx_data_q, tx_data_d, rx_buf_q, rx_buf_d, fifo_head, con_val;
   logic        tx_start_q, tx_start_d, irq_q, irq_d;
   logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
   logic        rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
   logic        txd_wr, con_wr, rxd_rd, fifo_pop, fifo_full, fifo_empty, tx_active;
   logic [CW-1:0] fifo_count;
   logic [31:0] rdata_c;
   logic        unused_bits;

   assign txd_wr = bus.mem_write && (bus.addr == ADDR_TXD);
   assign con_wr = bus.mem_write && (bus.addr == ADDR_CON);
   assign rxd_rd = bus.mem_read  && (bus.addr == ADDR_RXD);
   assign unused_bits = ^{bus.wdata[31:8], bus.wdata[5], bus.wdata[2:0], fifo_count};

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (txd_wr),
      .pop   (fifo_pop),
      .wdata (bus.wdata[7:0]),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_active = (state_q != TX_IDLE);
   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign irq       = irq_q;

   always_comb begin
      state_d    = state_q;
      fifo_pop   = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      unique case (state_q)
         TX_IDLE: begin
            if (!fifo_empty && !tx_busy) begin
               state_d    = TX_START;
               fifo_pop   = 1'b1;
               tx_data_d  = fifo_head;
               tx_start_d = 1'b1;
            end
         end
         TX_START:   state_d = TX_WAIT_HI;
         TX_WAIT_HI: if (tx_busy)  state_d = TX_WAIT_LO;
         TX_WAIT_LO: if (!tx_busy) state_d = TX_IDLE;
         default:    state_d = TX_IDLE;
      endcase
   end

   // Sticky flags: a set event in the same cycle as a write-1-to-clear wins.
   always_comb begin
      rx_buf_d    = rx_done ? rx_data : rx_buf_q;
      rx_valid_d  = rx_done | (rx_valid_q & ~rxd_rd);
      rx_ovr_d    = (rx_done & rx_valid_q & ~rxd_rd)
                  | (rx_ovr_q & ~(con_wr & bus.wdata[CON_RX_OVR]));
      tx_ovf_d    = (txd_wr & fifo_full & ~fifo_pop)
                  | (tx_ovf_q & ~(con_wr & bus.wdata[CON_TX_OVF]));
      rx_irq_en_d = con_wr ? bus.wdata[CON_RX_IRQ_EN] : rx_irq_en_q;
      tx_irq_en_d = con_wr ? bus.wdata[CON_TX_IRQ_EN] : tx_irq_en_q;
      irq_d       = (rx_irq_en_q & rx_valid_q) | (tx_irq_en_q & fifo_empty & ~tx_active);
   end

   always_comb begin
      con_val                = '0;
      con_val[CON_TX_EMPTY]  = fifo_empty;
      con_val[CON_TX_FULL]   = fifo_full;
      con_val[CON_RX_VALID]  = rx_valid_q;
      con_val[CON_TX_OVF]    = tx_ovf_q;
      con_val[CON_RX_OVR]    = rx_ovr_q;
      con_val[CON_TX_ACTIVE] = tx_active;
      con_val[CON_RX_IRQ_EN] = rx_irq_en_q;
      con_val[CON_TX_IRQ_EN] = tx_irq_en_q;
      rdata_c = '0;
      if (bus.mem_read) begin
         if (bus.addr == ADDR_RXD)      rdata_c = {24'b0, rx_buf_q};
         else if (bus.addr == ADDR_CON) rdata_c = {24'b0, con_val};
      end
   end

   assign bus.rdata = rdata_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= TX_IDLE;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         irq_q       <= 1'b0;
         rx_buf_q    <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_ovr_q    <= 1'b0;
         tx_ovf_q    <= 1'b0;
         rx_irq_en_q <= 1'b0;
         tx_irq_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         irq_q       <= irq_d;
         rx_buf_q    <= rx_buf_d;
         rx_valid_q  <= rx_valid_d;
         rx_ovr_q    <= rx_ovr_d;
         tx_ovf_q    <= tx_ovf_d;
         rx_irq_en_q <= rx_irq_en_d;
         tx_irq_en_q <= tx_irq_en_d;
      end
   end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: expected TX bytes and load data are
// queued at issue time and checked by an independent negedge monitor.
module tb_uart_mmio_ctrl;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       irq;
   logic       busy_force, busy_sender;
   int         sender_dur;

   uart_mmio_ctrl_if bus ();

   always #5 clk = ~clk;
   assign tx_busy = busy_force | busy_sender;

   uart_mmio_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .irq      (irq)
   );

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  tx_q [$];
   logic [31:0] rd_q [$];
   string       rd_name_q [$];
   logic        mon_prev = 1'b0;

   // reference model state
   bit          m_rx_valid, m_rx_ovr, m_tx_ovf, m_rxe, m_txe;
   logic [7:0]  m_rx_buf;
   int          m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] con_exp(input bit active, input bit full, input bit empty);
      return {24'b0, m_txe, m_rxe, active, m_rx_ovr, m_tx_ovf, m_rx_valid, full, empty};
   endfunction

   // sender model: busy rises at the negedge where start is seen
   initial begin
      busy_sender = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            busy_sender = 1'b1;
            repeat (sender_dur) @(negedge clk);
            busy_sender = 1'b0;
         end
      end
   end

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            chk("tx_start_width", {31'b0, mon_prev}, 32'd0);
            if (tx_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL tx_unexpected: got start with data %0h expected no start", tx_data);
            end else begin
               chk("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
            end
         end
         mon_prev = tx_start;
         if (bus.mem_read === 1'b1 && rd_q.size() > 0)
            chk(rd_name_q.pop_front(), bus.rdata, rd_q.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr = a; bus.wdata = d; bus.mem_write = 1'b1;
      @(posedge clk); #1;
      bus.mem_write = 1'b0;
   endtask

   task automatic bus_rd(input string n, input logic [31:0] a, input logic [31:0] exp);
      bus.addr = a; bus.mem_read = 1'b1;
      rd_q.push_back(exp);
      rd_name_q.push_back(n);
      @(posedge clk); #1;
      bus.mem_read = 1'b0;
   endtask

   task automatic txd(input logic [7:0] b);
      if (m_cnt < 4) begin
         m_cnt++;
         tx_q.push_back(b);
      end else begin
         m_tx_ovf = 1'b1;
      end
      bus_wr(ADDR_TXD, {24'($urandom), b});
   endtask

   task automatic rxb(input logic [7:0] b);
      if (m_rx_valid) m_rx_ovr = 1'b1;
      m_rx_valid = 1'b1;
      m_rx_buf   = b;
      rx_data = b; rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
   endtask

   task automatic rxd_read();
      bus_rd("rxd", ADDR_RXD, {24'b0, m_rx_buf});
      m_rx_valid = 1'b0;
   endtask

   task automatic con_wr(input logic [7:0] d);
      m_txe = d[7];
      m_rxe = d[6];
      if (d[4]) m_rx_ovr = 1'b0;
      if (d[3]) m_tx_ovf = 1'b0;
      bus_wr(ADDR_CON, {24'($urandom), d});
   endtask

   task automatic drain();
      int n = 0;
      while ((tx_q.size() != 0 || tx_busy) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d bytes pending expected 0", tx_q.size());
      end
      repeat (3) @(posedge clk);
      #1;
      m_cnt = 0;
   endtask

   task automatic model_reset();
      tx_q.delete();
      m_rx_valid = 0; m_rx_ovr = 0; m_tx_ovf = 0; m_rxe = 0; m_txe = 0;
      m_rx_buf = 8'h00; m_cnt = 0;
   endtask

   initial begin
      int k, nrx;
      reset = 1'b1;
      bus.addr = '0; bus.wdata = '0; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
      rx_data = 8'h00; rx_done = 1'b0; busy_force = 1'b0; sender_dur = 3;
      model_reset();

      #12;
      chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus_rd("con_reset", ADDR_CON, 32'h01);
      bus_rd("unmapped_read", 32'h4000_0024, 32'h0);
      bus_rd("txd_read", ADDR_TXD, 32'h0);

      // single byte
      sender_dur = 10;
      txd(8'h41);
      @(negedge clk);
      chk("start_lat_n", {31'b0, tx_start}, 32'd0);
      @(negedge clk);
      chk("start_lat_n1", {31'b0, tx_start}, 32'd1);
      chk("single_data", {24'b0, tx_data}, 32'h41);
      @(posedge clk); #1;
      drain();
      bus_rd("con_single", ADDR_CON, 32'h01);

      // FIFO full with sender held busy
      busy_force = 1'b1;
      sender_dur = 2;
      for (int i = 1; i <= 5; i++) txd(8'(i));
      bus_rd("con_full_ovf", ADDR_CON, con_exp(0, 1, 0));
      con_wr(8'h08);
      bus_rd("con_ovf_clr", ADDR_CON, con_exp(0, 1, 0));
      busy_force = 1'b0;
      drain();
      bus_rd("con_full_drained", ADDR_CON, 32'h01);

      // RX path
      rxb(8'h5A);
      bus_rd("con_rx_valid", ADDR_CON, con_exp(0, 0, 1));
      rxd_read();
      bus_rd("con_rx_read", ADDR_CON, 32'h01);
      rxb(8'hA5);
      rxb(8'hC3);
      bus_rd("con_rx_ovr", ADDR_CON, con_exp(0, 0, 1));
      rxd_read();
      con_wr(8'h10);
      bus_rd("con_ovr_clr", ADDR_CON, 32'h01);

      // read/receive collision
      rxb(8'h11);
      rx_data = 8'h77; rx_done = 1'b1;
      bus_rd("rxd_collide", ADDR_RXD, 32'h11);
      rx_done = 1'b0;
      m_rx_buf = 8'h77; m_rx_valid = 1'b1;
      bus_rd("con_collide", ADDR_CON, 32'h05);
      rxd_read();
      bus_rd("con_collide_after", ADDR_CON, 32'h01);

      // interrupts
      con_wr(8'h40);
      rxb(8'h33);
      chk("irq_rx_lag", {31'b0, irq}, 32'd0);
      @(posedge clk); #1;
      chk("irq_rx_set", {31'b0, irq}, 32'd1);
      rxd_read();
      chk("irq_rx_hold", {31'b0, irq}, 32'd1);
      @(posedge clk); #1;
      chk("irq_rx_drop", {31'b0, irq}, 32'd0);
      con_wr(8'h80);
      chk("irq_tx_lag", {31'b0, irq}, 32'd0);
      @(posedge clk); #1;
      chk("irq_tx_set", {31'b0, irq}, 32'd1);
      con_wr(8'h00);
      @(posedge clk); #1;
      chk("irq_tx_off", {31'b0, irq}, 32'd0);

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         busy_force = 1'b1;
         k = $urandom_range(1, 6);
         for (int j = 0; j < k; j++) txd(8'($urandom));
         bus_rd("con_rand_fill", ADDR_CON, con_exp(0, m_cnt == 4, 0));
         con_wr(8'h08);
         sender_dur = $urandom_range(2, 6);
         busy_force = 1'b0;
         drain();
         nrx = $urandom_range(1, 3);
         for (int j = 0; j < nrx; j++) rxb(8'($urandom));
         bus_rd("con_rand_rx", ADDR_CON, con_exp(0, 0, 1));
         rxd_read();
         con_wr(8'h10);
         bus_rd("con_rand_end", ADDR_CON, 32'h01);
      end

      // reset mid-transfer
      sender_dur = 20;
      txd(8'hA1);
      txd(8'hB2);
      txd(8'hC3);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_tx_start", {31'b0, tx_start}, 32'd0);
      chk("mid_rst_tx_data", {24'b0, tx_data}, 32'd0);
      chk("mid_rst_irq", {31'b0, irq}, 32'd0);
      chk("mid_rst_rdata", bus.rdata, 32'd0);
      bus_rd("con_in_reset", ADDR_CON, 32'h01);
      reset = 1'b0;
      bus_rd("con_after_reset", ADDR_CON, 32'h01);
      repeat (30) @(posedge clk);
      #1;
      sender_dur = 3;
      txd(8'hD4);
      drain();
      bus_rd("con_final", ADDR_CON, 32'h01);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
